// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a one-entry skid buffer and operand forwarding.
// Held operands are re-forwarded every cycle so late results still reach waiting instructions.
module id_ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic [5:0]  in_instr_id,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd_addr,
  input  logic        flush,
  input  logic        fwd_mem_we,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_we,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rs1,
  output logic [31:0] out_rs2,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic [5:0]  out_instr_id,
  output logic [4:0]  out_rd_addr
);

  typedef struct packed {
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [5:0]  id;
    logic [4:0]  rd;
  } entry_t;

  entry_t r_m, r_s;
  logic   r_m_valid, r_s_valid;
  entry_t w_in_ent, w_m_ref, w_s_ref;
  logic   w_in_fire, w_out_fire, w_m_load;

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (FWD_EN && a != 5'd0) begin
      if (fwd_mem_we && fwd_mem_rd == a) return fwd_mem_data;
      if (fwd_wb_we && fwd_wb_rd == a) return fwd_wb_data;
    end
    return d;
  endfunction

  assign in_ready   = ~r_s_valid & ~rst;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_m_valid & out_ready;
  assign w_m_load   = ~r_m_valid | w_out_fire;

  always_comb begin
    w_in_ent      = '0;
    w_in_ent.rs1a = in_rs1_addr;
    w_in_ent.rs2a = in_rs2_addr;
    w_in_ent.rs1  = fwd(in_rs1_addr, in_rs1_data);
    w_in_ent.rs2  = fwd(in_rs2_addr, in_rs2_data);
    w_in_ent.imm  = in_imm;
    w_in_ent.pc   = in_pc;
    w_in_ent.id   = in_instr_id;
    w_in_ent.rd   = in_rd_addr;

    w_m_ref     = r_m;
    w_m_ref.rs1 = fwd(r_m.rs1a, r_m.rs1);
    w_m_ref.rs2 = fwd(r_m.rs2a, r_m.rs2);

    w_s_ref     = r_s;
    w_s_ref.rs1 = fwd(r_s.rs1a, r_s.rs1);
    w_s_ref.rs2 = fwd(r_s.rs2a, r_s.rs2);
  end

  // in_ready is low whenever skid is full, so a skid->main refill never coincides with an input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m       <= '0;
      r_s       <= '0;
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m.id    <= '0;
    end else if (w_m_load) begin
      if (r_s_valid) begin
        r_m       <= w_s_ref;
        r_m_valid <= 1'b1;
        r_s_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_m       <= w_in_ent;
        r_m_valid <= 1'b1;
      end else begin
        r_m_valid <= 1'b0;
        r_m.id    <= '0;
      end
    end else begin
      r_m <= w_m_ref;
      if (w_in_fire) begin
        r_s       <= w_in_ent;
        r_s_valid <= 1'b1;
      end else if (r_s_valid) begin
        r_s <= w_s_ref;
      end
    end
  end

  assign out_valid    = r_m_valid;
  assign out_rs1      = r_m.rs1;
  assign out_rs2      = r_m.rs2;
  assign out_imm      = r_m.imm;
  assign out_pc       = r_m.pc;
  assign out_instr_id = r_m.id;
  assign out_rd_addr  = r_m.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: streaming, backpressure, forwarding, flush and async reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [5:0]  in_instr_id;
  logic        flush;
  logic        fwd_mem_we, fwd_wb_we;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1, out_rs2, out_imm, out_pc;
  logic [5:0]  out_instr_id;
  logic [4:0]  out_rd_addr;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_instr_id(in_instr_id), .in_pc(in_pc), .in_rd_addr(in_rd_addr),
    .flush(flush),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
    .out_instr_id(out_instr_id), .out_rd_addr(out_rd_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [5:0] id);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_instr_id = id;
    in_imm      = pc + 32'h100;
    in_rd_addr  = id[4:0];
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_instr_id = '0; in_pc = '0; in_rd_addr = '0;
    fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_we = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_instr_id", out_instr_id, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // streaming
    out_ready = 1'b1;
    drive(32'h00, 6'd1); step();
    chk("stream0_valid", out_valid, 1);
    chk("stream0_pc", out_pc, 32'h00);
    chk("stream0_imm", out_imm, 32'h100);
    chk("stream0_rd", out_rd_addr, 1);
    drive(32'h04, 6'd2); step();
    chk("stream1_pc", out_pc, 32'h04);
    drive(32'h08, 6'd3); step();
    chk("stream2_pc", out_pc, 32'h08);
    chk("stream2_id", out_instr_id, 3);
    in_valid = 1'b0; step();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_id", out_instr_id, 0);

    // backpressure
    out_ready = 1'b0;
    drive(32'h10, 6'd4); step();
    chk("bp_main_pc", out_pc, 32'h10);
    chk("bp_ready1", in_ready, 1);
    drive(32'h14, 6'd5); step();
    chk("bp_ready_full", in_ready, 0);
    drive(32'h18, 6'd6); step();
    chk("bp_hold_pc", out_pc, 32'h10);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_emit0_pc", out_pc, 32'h10);
    step();
    chk("bp_emit1_pc", out_pc, 32'h14);
    chk("bp_emit1_ready", in_ready, 1);
    step();
    chk("bp_emit2_pc", out_pc, 32'h18);
    chk("bp_emit2_id", out_instr_id, 6);
    in_valid = 1'b0; step();
    chk("bp_drain_valid", out_valid, 0);

    // forwarding priority
    drive(32'h20, 6'd7);
    in_rs1_addr = 5'd5; in_rs1_data = 32'h1;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hAAAA;
    fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd5; fwd_wb_data  = 32'hBBBB;
    step();
    chk("fwd_mem_wins", out_rs1, 32'hAAAA);
    fwd_mem_we = 1'b0; step();
    chk("fwd_wb", out_rs1, 32'hBBBB);
    fwd_wb_we = 1'b0; step();
    chk("fwd_none", out_rs1, 32'h1);

    // refresh of a held entry
    out_ready = 1'b0; in_valid = 1'b0;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h1234;
    step();
    chk("refresh_rs1", out_rs1, 32'h1234);
    fwd_mem_we = 1'b0;

    // x0 guard
    out_ready = 1'b1;
    drive(32'h30, 6'd8);
    in_rs1_addr = 5'd0; in_rs1_data = 32'h0;
    in_rs2_addr = 5'd0; in_rs2_data = 32'h0;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'hDEAD;
    step(); step();
    chk("x0_pc", out_pc, 32'h30);
    chk("x0_rs2", out_rs2, 32'h0);
    fwd_mem_we = 1'b0;
    in_valid = 1'b0; step();

    // flush with main and skid full
    out_ready = 1'b0;
    drive(32'h40, 6'd9); step();
    drive(32'h44, 6'd10); step();
    chk("fl_full_ready", in_ready, 0);
    flush = 1'b1; drive(32'h48, 6'd11); step();
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_id", out_instr_id, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl_nothing_emitted", out_valid, 0);

    // asynchronous reset between edges
    drive(32'h50, 6'd12); step();
    chk("ar_valid_before", out_valid, 1);
    chk("ar_pc_before", out_pc, 32'h50);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("ar_ready_release", in_ready, 1);
    step();
    chk("ar_stays_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
